// File: rtl/dataslot_cmd_sequencer.sv
// Memory-mapped sequencer that turns firmware register writes into APF target-dataslot
// read/write commands, with ack/done tracking, a timeout and a completion IRQ.
module dataslot_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic        bus_wr,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rsp_valid,
  output logic        irq,
  output logic        target_dataslot_read,
  output logic        target_dataslot_write,
  input  logic        target_dataslot_ack,
  input  logic        target_dataslot_done,
  input  logic [2:0]  target_dataslot_err,
  output logic [15:0] target_dataslot_id,
  output logic [31:0] target_dataslot_slotoffset,
  output logic [31:0] target_dataslot_bridgeaddr,
  output logic [31:0] target_dataslot_length
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        id_q, id_d;
  logic [31:0]        offset_q, offset_d;
  logic [31:0]        baddr_q, baddr_d;
  logic [31:0]        len_q, len_d;
  logic               ack_s1_q, ack_s1_d, ack_s_q, ack_s_d;
  logic               done_s1_q, done_s1_d, done_s_q, done_s_d;
  logic               rd_strobe_q, rd_strobe_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_done_q, flag_done_d;
  logic               flag_to_q, flag_to_d;
  logic               flag_rej_q, flag_rej_d;
  logic [2:0]         err_q, err_d;
  logic               irq_q, irq_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               busy;
  logic               wr_en;
  logic               rd_en;
  logic               cmd_wr;
  logic               timeout_hit;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    offset_d    = offset_q;
    baddr_d     = baddr_q;
    len_d       = len_q;
    ack_s1_d    = target_dataslot_ack;
    ack_s_d     = ack_s1_q;
    done_s1_d   = target_dataslot_done;
    done_s_d    = done_s1_q;
    rd_strobe_d = rd_strobe_q;
    wr_strobe_d = wr_strobe_q;
    cnt_d       = cnt_q;
    flag_done_d = flag_done_q;
    flag_to_d   = flag_to_q;
    flag_rej_d  = flag_rej_q;
    err_d       = err_q;
    irq_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = 32'd0;

    busy        = (state_q != StIdle);
    wr_en       = bus_valid & bus_wr;
    rd_en       = bus_valid & ~bus_wr;
    cmd_wr      = wr_en && (bus_addr == 3'd4);
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Parameter registers are frozen while a command is in flight.
    if (wr_en && !busy) begin
      case (bus_addr)
        3'd0:    id_d     = bus_wdata[15:0];
        3'd1:    offset_d = bus_wdata;
        3'd2:    baddr_d  = bus_wdata;
        3'd3:    len_d    = bus_wdata;
        default: ;
      endcase
    end

    // W1C clears come first so that hardware sets below take precedence.
    if (wr_en && (bus_addr == 3'd5)) begin
      if (bus_wdata[1]) flag_done_d = 1'b0;
      if (bus_wdata[2]) flag_to_d   = 1'b0;
      if (bus_wdata[3]) flag_rej_d  = 1'b0;
    end

    if (cmd_wr && busy) flag_rej_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cmd_wr) begin
          unique case (bus_wdata[1:0])
            2'b01, 2'b10: begin
              rd_strobe_d = bus_wdata[0];
              wr_strobe_d = bus_wdata[1];
              cnt_d       = '0;
              flag_done_d = 1'b0;
              flag_to_d   = 1'b0;
              state_d     = StIssue;
            end
            2'b11:   flag_rej_d = 1'b1;
            default: ;
          endcase
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        // done_s is deliberately ignored here: it may be left over from the last command.
        if (timeout_hit) begin
          rd_strobe_d = 1'b0;
          wr_strobe_d = 1'b0;
          flag_to_d   = 1'b1;
          err_d       = 3'b111;
          irq_d       = 1'b1;
          state_d     = StIdle;
        end else if (ack_s_q) begin
          rd_strobe_d = 1'b0;
          wr_strobe_d = 1'b0;
          state_d     = StWaitDone;
        end
      end
      StWaitDone: begin
        cnt_d = cnt_q + 1'b1;
        if (done_s_q) begin
          err_d       = target_dataslot_err;
          flag_done_d = 1'b1;
          irq_d       = 1'b1;
          state_d     = StIdle;
        end else if (timeout_hit) begin
          rd_strobe_d = 1'b0;
          wr_strobe_d = 1'b0;
          flag_to_d   = 1'b1;
          err_d       = 3'b111;
          irq_d       = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rd_en) begin
      rsp_valid_d = 1'b1;
      case (bus_addr)
        3'd0:    rdata_d = {16'd0, id_q};
        3'd1:    rdata_d = offset_q;
        3'd2:    rdata_d = baddr_q;
        3'd3:    rdata_d = len_q;
        3'd5:    rdata_d = {25'd0, err_q, flag_rej_q, flag_to_q, flag_done_q, busy};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      id_q        <= '0;
      offset_q    <= '0;
      baddr_q     <= '0;
      len_q       <= '0;
      ack_s1_q    <= 1'b0;
      ack_s_q     <= 1'b0;
      done_s1_q   <= 1'b0;
      done_s_q    <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      cnt_q       <= '0;
      flag_done_q <= 1'b0;
      flag_to_q   <= 1'b0;
      flag_rej_q  <= 1'b0;
      err_q       <= '0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      offset_q    <= offset_d;
      baddr_q     <= baddr_d;
      len_q       <= len_d;
      ack_s1_q    <= ack_s1_d;
      ack_s_q     <= ack_s_d;
      done_s1_q   <= done_s1_d;
      done_s_q    <= done_s_d;
      rd_strobe_q <= rd_strobe_d;
      wr_strobe_q <= wr_strobe_d;
      cnt_q       <= cnt_d;
      flag_done_q <= flag_done_d;
      flag_to_q   <= flag_to_d;
      flag_rej_q  <= flag_rej_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_ready                  = 1'b1;
  assign bus_rdata                  = rdata_q;
  assign bus_rsp_valid              = rsp_valid_q;
  assign irq                        = irq_q;
  assign target_dataslot_read       = rd_strobe_q;
  assign target_dataslot_write      = wr_strobe_q;
  assign target_dataslot_id         = id_q;
  assign target_dataslot_slotoffset = offset_q;
  assign target_dataslot_bridgeaddr = baddr_q;
  assign target_dataslot_length     = len_q;

endmodule

// File: tb/tb_dataslot_cmd_sequencer.sv
// Directed self-checking bench for dataslot_cmd_sequencer with a short timeout.
module tb_dataslot_cmd_sequencer;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wr;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rsp_valid;
  logic        irq;
  logic        ds_read;
  logic        ds_write;
  logic        ds_ack;
  logic        ds_done;
  logic [2:0]  ds_err;
  logic [15:0] ds_id;
  logic [31:0] ds_offset;
  logic [31:0] ds_baddr;
  logic [31:0] ds_len;

  int checks   = 0;
  int failures = 0;

  dataslot_cmd_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (32)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .bus_valid                 (bus_valid),
    .bus_ready                 (bus_ready),
    .bus_wr                    (bus_wr),
    .bus_addr                  (bus_addr),
    .bus_wdata                 (bus_wdata),
    .bus_rdata                 (bus_rdata),
    .bus_rsp_valid             (bus_rsp_valid),
    .irq                       (irq),
    .target_dataslot_read      (ds_read),
    .target_dataslot_write     (ds_write),
    .target_dataslot_ack       (ds_ack),
    .target_dataslot_done      (ds_done),
    .target_dataslot_err       (ds_err),
    .target_dataslot_id        (ds_id),
    .target_dataslot_slotoffset(ds_offset),
    .target_dataslot_bridgeaddr(ds_baddr),
    .target_dataslot_length    (ds_len)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_valid = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus_valid = 1'b1; bus_wr = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_valid = 1'b0;
    d = bus_rdata;
    v = bus_rsp_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ds_read, ds_write, irq, bus_rsp_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000", {ds_read, ds_write, irq, bus_rsp_valid});
    end
    checks++;
    if ({bus_rdata, ds_id, ds_offset, ds_baddr, ds_len} !== 144'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus_rdata, ds_id, ds_offset, ds_baddr, ds_len});
    end
    checks++;
    if (bus_ready !== 1'b1) begin
      failures++;
      $display("FAIL bus_ready got=%b exp=1", bus_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_cmd;
    logic [31:0] d;
    logic        v;
    bus_write(3'd0, 32'h0000_0003);
    bus_write(3'd1, 32'h0000_0100);
    bus_write(3'd2, 32'h1000_0000);
    bus_write(3'd3, 32'h0000_0200);
    bus_read(3'd0, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'h3}) begin
      failures++;
      $display("FAIL rd_id got=%b/%h exp=1/00000003", v, d);
    end
    @(negedge clk);
    checks++;
    if ({bus_rsp_valid, bus_rdata} !== 33'd0) begin
      failures++;
      $display("FAIL rsp_idle got=%b/%h exp=0/0", bus_rsp_valid, bus_rdata);
    end
    bus_read(3'd4, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL rd_cmd got=%b/%h exp=1/0", v, d);
    end
    bus_read(3'd7, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL rd_idx7 got=%b/%h exp=1/0", v, d);
    end
    bus_write(3'd4, 32'h1);
    checks++;
    if ({ds_read, ds_write, ds_id, ds_offset, ds_baddr, ds_len} !==
        {2'b10, 16'h0003, 32'h100, 32'h1000_0000, 32'h200}) begin
      failures++;
      $display("FAIL issue_read got=%b%b %h %h %h %h", ds_read, ds_write, ds_id, ds_offset,
               ds_baddr, ds_len);
    end
    ds_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (ds_read !== (i < 3)) begin
        failures++;
        $display("FAIL ack_drop cyc=%0d got=%b exp=%b", i, ds_read, (i < 3));
      end
    end
    ds_done = 1'b1;
    ds_err  = 3'd0;
    for (int i = 4; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (irq !== (i == 6)) begin
        failures++;
        $display("FAIL done_irq cyc=%0d got=%b exp=%b", i, irq, (i == 6));
      end
    end
    ds_ack  = 1'b0;
    ds_done = 1'b0;
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h02) begin
      failures++;
      $display("FAIL status_ok got=%h exp=00000002", d);
    end
  endtask

  task automatic test_write_cmd;
    logic [31:0] d;
    logic        v;
    logic        saw_rd;
    logic        got_irq;
    repeat (3) @(negedge clk);
    bus_write(3'd4, 32'h2);
    checks++;
    if ({ds_read, ds_write} !== 2'b01) begin
      failures++;
      $display("FAIL issue_write got=%b exp=01", {ds_read, ds_write});
    end
    ds_ack = 1'b1;
    saw_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ds_read) saw_rd = 1'b1;
      if (!ds_write) break;
    end
    checks++;
    if ({saw_rd, ds_write} !== 2'b00) begin
      failures++;
      $display("FAIL write_only got=%b exp=00", {saw_rd, ds_write});
    end
    ds_done = 1'b1;
    ds_err  = 3'b010;
    got_irq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq) begin
        got_irq = 1'b1;
        break;
      end
    end
    checks++;
    if (got_irq !== 1'b1) begin
      failures++;
      $display("FAIL write_irq got=%b exp=1", got_irq);
    end
    ds_ack  = 1'b0;
    ds_done = 1'b0;
    ds_err  = 3'd0;
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h22) begin
      failures++;
      $display("FAIL status_err got=%h exp=00000022", d);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    logic        v;
    int          irqs;
    int          bad_hi;
    repeat (3) @(negedge clk);
    bus_write(3'd4, 32'h1);
    irqs   = 0;
    bad_hi = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (!ds_read) bad_hi++;
      if (irq) irqs++;
    end
    checks++;
    if (bad_hi !== 0) begin
      failures++;
      $display("FAIL to_hold got=%0d low cycles exp=0", bad_hi);
    end
    @(negedge clk);
    if (irq) irqs++;
    checks++;
    if (ds_read !== 1'b0) begin
      failures++;
      $display("FAIL to_drop got=%b exp=0", ds_read);
    end
    repeat (4) begin
      @(negedge clk);
      if (irq) irqs++;
    end
    checks++;
    if (irqs !== 1) begin
      failures++;
      $display("FAIL to_irq_count got=%0d exp=1", irqs);
    end
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h74) begin
      failures++;
      $display("FAIL status_to got=%h exp=00000074", d);
    end
  endtask

  task automatic test_busy_reject;
    logic [31:0] d;
    logic        v;
    logic        got_irq;
    bus_write(3'd4, 32'h1);
    bus_write(3'd4, 32'h1);
    bus_write(3'd3, 32'h0000_FFFF);
    checks++;
    if ({ds_read, ds_len} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL busy_hold got=%b/%h exp=1/00000200", ds_read, ds_len);
    end
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h79) begin
      failures++;
      $display("FAIL status_rej got=%h exp=00000079", d);
    end
    bus_write(3'd5, 32'h08);
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h71) begin
      failures++;
      $display("FAIL status_w1c got=%h exp=00000071", d);
    end
    got_irq = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (irq) begin
        got_irq = 1'b1;
        break;
      end
    end
    checks++;
    if (got_irq !== 1'b1) begin
      failures++;
      $display("FAIL busy_to_irq got=%b exp=1", got_irq);
    end
  endtask

  task automatic test_stale_done;
    logic [31:0] d;
    logic        v;
    int          bad;
    ds_done = 1'b1;
    ds_err  = 3'd0;
    repeat (3) @(negedge clk);
    bus_write(3'd4, 32'h1);
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (irq || !ds_read) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stale_done got=%0d bad cycles exp=0", bad);
    end
    ds_ack = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if ({ds_read, irq} !== {(i < 7), (i == 8)}) begin
        failures++;
        $display("FAIL stale_seq cyc=%0d got=%b exp=%b", i, {ds_read, irq}, {(i < 7), (i == 8)});
      end
    end
    ds_ack  = 1'b0;
    ds_done = 1'b0;
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h02) begin
      failures++;
      $display("FAIL status_stale got=%h exp=00000002", d);
    end
    bus_write(3'd4, 32'h3);
    checks++;
    if ({ds_read, ds_write} !== 2'b00) begin
      failures++;
      $display("FAIL both_bits got=%b exp=00", {ds_read, ds_write});
    end
    bus_read(3'd5, d, v);
    checks++;
    if (d !== 32'h0A) begin
      failures++;
      $display("FAIL status_both got=%h exp=0000000a", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        v;
    int          irqs;
    repeat (3) @(negedge clk);
    bus_write(3'd4, 32'h2);
    ds_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(3'd5, d, v);
    checks++;
    if ({ds_write, d} !== {1'b0, 32'h09}) begin
      failures++;
      $display("FAIL wait_done got=%b/%h exp=0/00000009", ds_write, d);
    end
    ds_done = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    checks++;
    if ({ds_read, ds_write, irq, bus_rsp_valid, bus_rdata, ds_id, ds_offset, ds_baddr, ds_len}
        !== 148'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b%b%b%b %h %h %h %h %h", ds_read, ds_write, irq,
               bus_rsp_valid, bus_rdata, ds_id, ds_offset, ds_baddr, ds_len);
    end
    irqs = 0;
    repeat (2) begin
      @(negedge clk);
      if (irq) irqs++;
    end
    reset   = 1'b0;
    ds_ack  = 1'b0;
    ds_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (irq) irqs++;
    end
    checks++;
    if (irqs !== 0) begin
      failures++;
      $display("FAIL reset_irq got=%0d exp=0", irqs);
    end
    bus_read(3'd5, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL status_after_rst got=%b/%h exp=1/0", v, d);
    end
    bus_write(3'd4, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ds_read, irq} !== 2'b00) begin
      failures++;
      $display("FAIL reset_issue got=%b exp=00", {ds_read, irq});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus_valid = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = 3'd0;
    bus_wdata = 32'd0;
    ds_ack    = 1'b0;
    ds_done   = 1'b0;
    ds_err    = 3'd0;
    test_reset();
    test_read_cmd();
    test_write_cmd();
    test_timeout();
    test_busy_reject();
    test_stale_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dataslot_cmd_sequencer.md
Name: dataslot_cmd_sequencer

Overview:
- Memory-mapped command sequencer between the VexRiscv data bus (simple cmd/rsp protocol) and the APF target-dataslot command interface.
- Firmware programs the slot ID, slot offset, bridge address and length, then writes a start command.
- The block raises target_dataslot_read or target_dataslot_write, tracks ack and done with a timeout, and reports the result through status bits and a one-cycle IRQ.

Parameters:
- TIMEOUT_CYCLES, 50000000: clk cycles allowed from issue to done before the command is aborted. Must be at least 2.
- CNT_W, 32: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- bus_valid  in  1  CPU command valid
- bus_ready  out  1  command accepted; tied to 1
- bus_wr  in  1  1 = write, 0 = read
- bus_addr  in  3  word index
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data
- bus_rsp_valid  out  1  read-data valid pulse
- irq  out  1  one-cycle completion pulse
- target_dataslot_read  out  1  read command request
- target_dataslot_write  out  1  write command request
- target_dataslot_ack  in  1  command accepted by host (level)
- target_dataslot_done  in  1  command finished (level)
- target_dataslot_err  in  3  result code; 0 = OK
- target_dataslot_id  out  16  slot ID
- target_dataslot_slotoffset  out  32  slot offset
- target_dataslot_bridgeaddr  out  32  bridge address
- target_dataslot_length  out  32  transfer length

Behaviour:
- Register map (word index):
  - 0 ID[15:0], R/W
  - 1 SLOTOFFSET, R/W
  - 2 BRIDGEADDR, R/W
  - 3 LENGTH, R/W
  - 4 CMD: write-only; bit0 = start read, bit1 = start write; reads as 0
  - 5 STATUS:
    - bit0 busy (RO)
    - bit1 done (W1C)
    - bit2 timeout (W1C)
    - bit3 reject (W1C)
    - bits[6:4] err (RO, last captured)
  - 6, 7 read as 0; writes ignored
- Bus timing:
  - bus_ready is constant 1.
  - A read is accepted on the cycle bus_valid=1 and bus_wr=0. bus_rsp_valid=1 and bus_rdata are presented exactly one cycle later.
  - Writes produce no response.
  - bus_rdata is 0 whenever bus_rsp_valid=0.
- Synchronisation: ack and done pass through 2-flop synchronisers (ack_s, done_s). This adds 2 cycles of input latency.
- Parameter registers drive the target_dataslot_* outputs directly.
  - Writes to indices 0–3 while busy are ignored, so the outputs stay stable for the whole command.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE:
    - A CMD write with exactly one of bit0/bit1 set starts a command: next cycle state=ISSUE, the matching strobe=1, timeout counter=0, done/timeout flags cleared.
    - CMD with both bits set, or neither, sets reject (both bits) or does nothing (neither). State stays IDLE.
  - ISSUE:
    - The strobe is held at 1 until ack_s=1.
    - On that cycle the strobe drops and the next state is WAIT_DONE.
    - done_s is ignored in ISSUE, because a stale done from the previous command may still be high.
  - WAIT_DONE:
    - On done_s=1, err is captured from target_dataslot_err, the done flag is set, irq pulses for 1 cycle, and the state returns to IDLE.
  - Timeout:
    - The counter increments each cycle in ISSUE and WAIT_DONE.
    - When it reaches TIMEOUT_CYCLES-1, the strobe is forced to 0, the timeout flag is set, err is set to 3'b111, irq pulses, and the state returns to IDLE.
    - If done_s and timeout occur in the same cycle, done wins.
- busy = (state != IDLE).
- A CMD write while busy is ignored and sets reject.
- A W1C write and a hardware set of the same flag in the same cycle: set wins.
- Reset values:
  - state IDLE
  - all strobes, irq, bus_rsp_valid, bus_rdata at 0
  - ID/offset/addr/length at 0
  - all flags and err at 0
  - synchronisers at 0
- Reset asserted mid-command drops the strobe on the next edge. No irq is generated.

Test Plan:
- Program ID=0x0003, OFFSET=0x100, BRIDGE=0x1000_0000, LEN=0x200; write CMD=1 → target_dataslot_read=1 one cycle later, outputs equal the programmed values. Raise ack → strobe low 3 cycles later. Raise done with err=0 → irq pulse; STATUS reads 0x02.
- Write command with err=3'b010 at done → STATUS=0x22; target_dataslot_write was the only strobe asserted.
- TIMEOUT_CYCLES=16, ack never asserted → strobe drops on cycle 16 after issue; STATUS=0x74; one irq pulse.
- While busy: write CMD=1 and LEN=0xFFFF → state unchanged, LEN output unchanged, STATUS bit3=1. Write STATUS=0x08 → bit3 clears.
- done left high from the previous command, new CMD=1 issued → no completion until ack_s rises and then done_s is seen. CMD=3 in IDLE → reject=1, no strobe.
- Assert reset during WAIT_DONE → all outputs 0 the next cycle, no irq; read of STATUS returns 0 with bus_rsp_valid one cycle after the request.
